dmac_bus: RTL
=============

# dmac_bus

Shared single-clock system bus that is the responding end of the DMAC master port. It arbitrates between two bus initiators (M0: host/testbench CPU, M1: DMAC master), returns `grant` to the winner, and routes the winner's address, write enable and write data to one of two slaves. S0 is the DMAC register slave; S1 is the data memory. It also multiplexes the selected slave's read data back to both masters.

## Interface
Parameters:
- `S0_PREFIX`, default 3'b000: `address[7:5]` value that selects S0 (DMAC registers, 0x00–0x1F).
- `S1_PREFIX`, default 3'b001: `address[7:5]` value that selects S1 (memory, 0x20–0x3F).

Ports:
- `clk` in 1: system clock, all state on rising edge.
- `reset_n` in 1: reset, asynchronous active-low.
- `M0_req` in 1: M0 bus request.
- `M0_wr` in 1: M0 write (1) / read (0).
- `M0_address` in 8: M0 address.
- `M0_dout` in 32: M0 write data.
- `M1_req` in 1: M1 (DMAC) bus request.
- `M1_wr` in 1: M1 write / read.
- `M1_address` in 8: M1 address.
- `M1_dout` in 32: M1 write data.
- `M0_grant` out 1: M0 owns the bus.
- `M1_grant` out 1: M1 owns the bus.
- `M_din` out 32: read data returned to both masters.
- `S0_sel` out 1: S0 select.
- `S1_sel` out 1: S1 select.
- `S_wr` out 1: write enable to slaves.
- `S_address` out 8: address to slaves.
- `S_din` out 32: write data to slaves.
- `S0_dout` in 32: S0 read data, registered inside S0.
- `S1_dout` in 32: S1 read data, registered inside S1.

## Operation
Arbiter FSM, state register only; `grant` is decoded from the state:
- `GNT_M0`: `M0_grant`=1, `M1_grant`=0. Reset state.
  - Go to `GNT_M1` when `M0_req`=0 and `M1_req`=1.
  - Otherwise stay.
- `GNT_M1`: `M1_grant`=1, `M0_grant`=0.
  - Go to `GNT_M0` when `M1_req`=0.
  - Otherwise stay.
- No preemption. The owner keeps the bus while its `req` stays high.
- Exactly one grant is high at all times, including during and after reset.
- Both `req` high while in `GNT_M0` keeps M0 (parked-owner priority). M1 waits until M0 drops `req`.

Datapath (combinational from the current state):
- `S_wr`, `S_address` and `S_din` come from the granted master's `wr`, `address` and `dout`.
- The path is not gated by `req`.
- `S_wr` is forced to 0 when the granted master's `req`=0, so an idle bus never writes.

Decoder (combinational on `S_address[7:5]`):
- `S0_sel`=1 when `S_address[7:5]`==`S0_PREFIX`.
- `S1_sel`=1 when `S_address[7:5]`==`S1_PREFIX`.
- Any other prefix: both selects 0. Writes are dropped; reads return 0.
- At most one select is high.

Read mux:
- A 2-bit register `rsel` captures {`S1_sel`,`S0_sel`} every cycle.
- `M_din` = `S0_dout` if `rsel`==2'b01, `S1_dout` if `rsel`==2'b10, else 32'h0.

## Timing
- Reset (asynchronous assertion):
  - state=`GNT_M0`, so `M0_grant`=1 and `M1_grant`=0.
  - `rsel`=0, so `M_din`=0.
  - `S_*` outputs follow M0's inputs; `S_wr`=0 if `M0_req`=0.
  - Reset is released on the next `clk` edge after `reset_n` rises.
- Grant latency:
  - Request edge at cycle N yields grant at cycle N+1, since the state updates on the edge after `req` is sampled.
  - Handover M0→M1: M0 drops `req` at edge N, `M1_grant` rises at N+1. There is no dead cycle between owners.
- Write: takes effect at the slave on the same edge that the slave samples `S_sel`/`S_wr`/`S_din`, i.e. 0 cycles of bus latency.
- Read: address presented in cycle N, data valid on `M_din` in cycle N+1. The slave registers its data and `rsel` aligns the mux to it.
- Back-to-back reads to alternating slaves: each `M_din` matches the slave addressed one cycle earlier.
- Grant switches mid-read: the cycle N+1 data still belongs to the master that owned cycle N. Masters must hold `req` through the data cycle.
- Reset mid-transfer: the grant returns to M0 immediately, and M1's transaction is abandoned with no further `S_wr`.

## Test plan
- Reset with `M0_req`=`M1_req`=0:
  - `M0_grant`=1, `M1_grant`=0, `M_din`=0, `S_wr`=0.
  - Holds for 5 idle cycles.
- M1 alone requests at edge N, with `M0_req`=0:
  - `M1_grant`=1 at N+1.
  - M1 writes 0x20←0xDEADBEEF: `S1_sel`=1, `S_wr`=1, `S_din`=0xDEADBEEF.
  - Read of 0x20 with `S1_dout`=0xDEADBEEF: `M_din`=0xDEADBEEF one cycle later.
- Both request together while in `GNT_M0`:
  - M0 keeps the grant for 4 cycles.
  - M0 drops `req` at edge K: `M1_grant`=1 at K+1.
  - M1 drops `req`: `M0_grant`=1 the next cycle.
- Decode:
  - Address 0x04 → `S0_sel`=1.
  - Address 0x3C → `S1_sel`=1.
  - Address 0x80 → both selects 0, and `M_din`=0 the next cycle with `S0_dout`=0x11111111 and `S1_dout`=0x22222222.
- Alternating reads 0x00, 0x20, 0x04:
  - `S0_dout`=0xA, `S1_dout`=0xB.
  - `M_din` is 0xA, 0xB, 0xA, each one cycle after its address.
- `reset_n` pulsed low mid-way while M1 is granted and writing:
  - `M1_grant`=0 and `M0_grant`=1 immediately (asynchronous).
  - `S_wr`=0 when `M0_req`=0.
  - `M_din`=0.

Source files
------------

// File: rtl/dmac_bus.sv
// Shared system bus: two-master arbiter (host CPU, DMAC master) with address
// decode to the DMAC register slave and data memory, plus a read-data return mux.
module dmac_bus #(
   parameter logic [2:0] S0_PREFIX = 3'b000,
   parameter logic [2:0] S1_PREFIX = 3'b001
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        M0_req,
   input  logic        M0_wr,
   input  logic [7:0]  M0_address,
   input  logic [31:0] M0_dout,
   input  logic        M1_req,
   input  logic        M1_wr,
   input  logic [7:0]  M1_address,
   input  logic [31:0] M1_dout,
   output logic        M0_grant,
   output logic        M1_grant,
   output logic [31:0] M_din,
   output logic        S0_sel,
   output logic        S1_sel,
   output logic        S_wr,
   output logic [7:0]  S_address,
   output logic [31:0] S_din,
   input  logic [31:0] S0_dout,
   input  logic [31:0] S1_dout
);

   typedef enum logic {
      GNT_M0 = 1'b0,
      GNT_M1 = 1'b1
   } state_t;

   state_t      state_r;
   state_t      state_next_s;
   logic [1:0]  rsel_r;
   logic        s0_sel_s;
   logic        s1_sel_s;

   // Arbiter state register; reset parks the bus on M0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= GNT_M0;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Arbiter next state: owner keeps the bus while it requests, no preemption.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         GNT_M0: begin
            if (!M0_req && M1_req) begin
               state_next_s = GNT_M1;
            end else begin
               state_next_s = GNT_M0;
            end
         end
         GNT_M1: begin
            if (!M1_req) begin
               state_next_s = GNT_M0;
            end else begin
               state_next_s = GNT_M1;
            end
         end
         default: state_next_s = GNT_M0;
      endcase
   end

   // Grants decoded straight from the state so exactly one is always high.
   always_comb begin
      M0_grant = 1'b1;
      M1_grant = 1'b0;
      case (state_r)
         GNT_M0: begin
            M0_grant = 1'b1;
            M1_grant = 1'b0;
         end
         GNT_M1: begin
            M0_grant = 1'b0;
            M1_grant = 1'b1;
         end
         default: begin
            M0_grant = 1'b1;
            M1_grant = 1'b0;
         end
      endcase
   end

   // Route the owner's request to the slaves; an idle owner never writes.
   always_comb begin
      S_wr      = 1'b0;
      S_address = M0_address;
      S_din     = M0_dout;
      if (state_r == GNT_M1) begin
         S_wr      = M1_req & M1_wr;
         S_address = M1_address;
         S_din     = M1_dout;
      end else begin
         S_wr      = M0_req & M0_wr;
         S_address = M0_address;
         S_din     = M0_dout;
      end
   end

   // Address decode; S0 wins if both prefixes were configured identical.
   always_comb begin
      s0_sel_s = 1'b0;
      s1_sel_s = 1'b0;
      if (S_address[7:5] == S0_PREFIX) begin
         s0_sel_s = 1'b1;
      end else if (S_address[7:5] == S1_PREFIX) begin
         s1_sel_s = 1'b1;
      end else begin
         s0_sel_s = 1'b0;
         s1_sel_s = 1'b0;
      end
   end

   assign S0_sel = s0_sel_s;
   assign S1_sel = s1_sel_s;

   // Remember which slave was addressed so the mux lines up with its registered data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsel_r <= 2'b00;
      end else begin
         rsel_r <= {s1_sel_s, s0_sel_s};
      end
   end

   // Read-data return; unmapped addresses read back as zero.
   always_comb begin
      M_din = 32'h0000_0000;
      case (rsel_r)
         2'b01:   M_din = S0_dout;
         2'b10:   M_din = S1_dout;
         default: M_din = 32'h0000_0000;
      endcase
   end

endmodule
